trace_dispatch: RTL and testbench

- Upstream stage of the cache hierarchy. Accepts trace commands (opcode n plus 32-bit address) from the trace-file reader through a valid/ready handshake.
- Buffers them in a small in-order FIFO.
- Routes each command to the instruction cache, the data cache, or the cache-clear / stats-print strobes.
- Produces the add_in/n/done/clear traffic that the top-level currently drives directly.

---
 rtl/trace_dispatch.sv | 120 ++++++++++++
 tb/tb_trace_dispatch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dispatch.sv
// Trace command dispatcher: buffers trace commands in an in-order FIFO and
// routes the head entry to the I-cache, the D-cache, or the flush/print strobes.
// Ports: clk, clear (sync active-low reset), cmd_valid/cmd_ready/cmd_n/cmd_add
//   from the trace reader; i_valid/i_ready/i_add to the I-cache;
//   d_valid/d_ready/d_op/d_add to the D-cache; flush and print one-cycle strobes;
//   occupancy (FIFO entry count) and err_cnt (saturating count of dropped
//   illegal opcodes).
module trace_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_n,
    input  logic [AW-1:0]              cmd_add,
    output logic                       i_valid,
    input  logic                       i_ready,
    output logic [AW-1:0]              i_add,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [1:0]                 d_op,
    output logic [AW-1:0]              d_add,
    output logic                       flush,
    output logic                       print,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    n_mem [DEPTH];
    logic [AW-1:0] a_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   err_q;

    logic          has_head;
    logic [3:0]    head_n;
    logic [AW-1:0] head_a;
    logic          is_i;
    logic          is_d;
    logic          is_f;
    logic          is_p;
    logic          is_bad;
    logic [1:0]    d_code;
    logic          push;
    logic          pop;

    // Outputs are forced to their idle values while clear is low so the
    // reset cycle itself already presents a clean, empty interface.
    assign has_head  = clear && (count != '0);
    assign head_n    = n_mem[rd_ptr];
    assign head_a    = a_mem[rd_ptr];
    assign cmd_ready = !clear || (count != CW'(DEPTH));
    assign occupancy = clear ? count : '0;
    assign err_cnt   = err_q;

    always_comb begin
        is_i   = 1'b0;
        is_d   = 1'b0;
        is_f   = 1'b0;
        is_p   = 1'b0;
        is_bad = 1'b0;
        d_code = 2'd0;
        case (head_n)
            4'd0:    begin is_d = 1'b1; d_code = 2'd0; end
            4'd1:    begin is_d = 1'b1; d_code = 2'd1; end
            4'd2:    is_i = 1'b1;
            4'd3:    begin is_d = 1'b1; d_code = 2'd2; end
            4'd4:    begin is_d = 1'b1; d_code = 2'd3; end
            4'd8:    is_f = 1'b1;
            4'd9:    is_p = 1'b1;
            default: is_bad = 1'b1;
        endcase
    end

    assign i_valid = has_head && is_i;
    assign d_valid = has_head && is_d;
    assign flush   = has_head && is_f;
    assign print   = has_head && is_p;
    assign i_add   = i_valid ? head_a : '0;
    assign d_add   = d_valid ? head_a : '0;
    assign d_op    = d_valid ? d_code : 2'd0;

    // Strobes and illegal entries never wait on a consumer.
    assign push = clear && cmd_valid && cmd_ready;
    assign pop  = (i_valid && i_ready) || (d_valid && d_ready) ||
                  flush || print || (has_head && is_bad);

    always_ff @(posedge clk) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= '0;
        end else begin
            if (push) begin
                n_mem[wr_ptr] <= cmd_n;
                a_mem[wr_ptr] <= cmd_add;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop && is_bad && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_dispatch.sv
// Testbench for trace_dispatch: table-driven single-cycle vectors plus
// hand-written sequences for backpressure, reset and err_cnt saturation.
module tb_trace_dispatch;

    logic        clk = 1'b0;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_n;
    logic [31:0] cmd_add;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_add;
    logic        d_valid;
    logic        d_ready;
    logic [1:0]  d_op;
    logic [31:0] d_add;
    logic        flush;
    logic        print;
    logic [2:0]  occupancy;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_dispatch #(.DEPTH(4), .AW(32)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_n     (cmd_n),
        .cmd_add   (cmd_add),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_add     (i_add),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_op      (d_op),
        .d_add     (d_add),
        .flush     (flush),
        .print     (print),
        .occupancy (occupancy),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic        clr;
        logic        v;
        logic [3:0]  n;
        logic [31:0] a;
        logic        ir;
        logic        dr;
        logic        er;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [1:0]  op;
        logic [31:0] da;
        logic        fl;
        logic        pr;
        logic [2:0]  oc;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic clr, input logic v, input logic [3:0] n,
        input logic [31:0] a, input logic ir, input logic dr,
        input logic er, input logic iv, input logic [31:0] ia,
        input logic dv, input logic [1:0] op, input logic [31:0] da,
        input logic fl, input logic pr, input logic [2:0] oc,
        input logic [15:0] ec);
        vec_t t;
        t.clr = clr; t.v = v; t.n = n; t.a = a; t.ir = ir; t.dr = dr;
        t.er = er; t.iv = iv; t.ia = ia; t.dv = dv; t.op = op;
        t.da = da; t.fl = fl; t.pr = pr; t.oc = oc; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic clr, input logic v, input logic [3:0] n,
                       input logic [31:0] a, input logic ir,
                       input logic dr);
        clear     = clr;
        cmd_valid = v;
        cmd_n     = n;
        cmd_add   = a;
        i_ready   = ir;
        d_ready   = dr;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input vec_t t, input int k);
        chk($sformatf("v%0d cmd_ready", k), 32'(cmd_ready), 32'(t.er));
        chk($sformatf("v%0d i_valid", k), 32'(i_valid), 32'(t.iv));
        chk($sformatf("v%0d i_add", k), i_add, t.ia);
        chk($sformatf("v%0d d_valid", k), 32'(d_valid), 32'(t.dv));
        chk($sformatf("v%0d d_op", k), 32'(d_op), 32'(t.op));
        chk($sformatf("v%0d d_add", k), d_add, t.da);
        chk($sformatf("v%0d flush", k), 32'(flush), 32'(t.fl));
        chk($sformatf("v%0d print", k), 32'(print), 32'(t.pr));
        chk($sformatf("v%0d occupancy", k), 32'(occupancy), 32'(t.oc));
        chk($sformatf("v%0d err_cnt", k), 32'(err_cnt), 32'(t.ec));
    endtask

    initial begin
        // reset, with a command presented during reset that must be ignored
        tbl.push_back(mk(0,1,2,32'h999,0,0, 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0,0,0,0,0,0));
        // basic instruction fetch
        tbl.push_back(mk(1,1,2,32'h1040,1,0, 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0, 1,1,32'h1040,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,0, 1,0,0,0,0,0,0,0,0,0));
        // data opcodes back-to-back
        tbl.push_back(mk(1,1,0,32'h100,0,1, 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h104,0,1, 1,0,0,1,0,32'h100,0,0,1,0));
        tbl.push_back(mk(1,1,3,32'h108,0,1, 1,0,0,1,1,32'h104,0,0,1,0));
        tbl.push_back(mk(1,1,4,32'h10C,0,1, 1,0,0,1,2,32'h108,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,       1,0,0,1,3,32'h10C,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,       1,0,0,0,0,0,0,0,0,0));
        // strobes in order
        tbl.push_back(mk(1,1,1,32'h200,0,1, 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,8,32'h0,0,1,   1,0,0,1,1,32'h200,0,0,1,0));
        tbl.push_back(mk(1,1,9,32'h0,0,1,   1,0,0,0,0,0,1,0,1,0));
        tbl.push_back(mk(1,1,0,32'h204,0,1, 1,0,0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,       1,0,0,1,0,32'h204,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,       1,0,0,0,0,0,0,0,0,0));
        // illegal opcodes
        tbl.push_back(mk(1,1,5,32'h300,1,1,  1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,6,32'h304,1,1,  1,0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,1,15,32'h308,1,1, 1,0,0,0,0,0,0,0,1,1));
        tbl.push_back(mk(1,0,0,0,1,1,        1,0,0,0,0,0,0,0,1,2));
        tbl.push_back(mk(1,0,0,0,1,1,        1,0,0,0,0,0,0,0,0,3));

        clear = 1'b0; cmd_valid = 1'b0; cmd_n = '0; cmd_add = '0;
        i_ready = 1'b0; d_ready = 1'b0;
        nxt();

        for (int k = 0; k < tbl.size(); k++) begin
            drv(tbl[k].clr, tbl[k].v, tbl[k].n, tbl[k].a,
                tbl[k].ir, tbl[k].dr);
            chk_vec(tbl[k], k);
            nxt();
        end

        // backpressure: five fetches with i_ready low
        for (int k = 0; k < 4; k++) begin
            drv(1, 1, 2, 32'h400 + 32'(4 * k), 0, 0);
            chk($sformatf("full occ%0d", k), 32'(occupancy), 32'(k));
            chk($sformatf("full rdy%0d", k), 32'(cmd_ready), 32'd1);
            if (k > 0) chk($sformatf("full ia%0d", k), i_add, 32'h400);
            nxt();
        end
        drv(1, 1, 2, 32'h410, 0, 0);
        chk("full occ4", 32'(occupancy), 32'd4);
        chk("full rdy4", 32'(cmd_ready), 32'd0);
        chk("full hold ia", i_add, 32'h400);
        nxt();
        drv(1, 1, 2, 32'h410, 1, 0);
        chk("release rdy", 32'(cmd_ready), 32'd0);
        chk("release iv", 32'(i_valid), 32'd1);
        chk("release ia", i_add, 32'h400);
        nxt();
        drv(1, 1, 2, 32'h410, 1, 0);
        chk("reassert rdy", 32'(cmd_ready), 32'd1);
        chk("reassert occ", 32'(occupancy), 32'd3);
        chk("drain ia1", i_add, 32'h404);
        nxt();
        for (int k = 2; k < 5; k++) begin
            drv(1, 0, 0, 0, 1, 0);
            chk($sformatf("drain ia%0d", k), i_add, 32'h400 + 32'(4 * k));
            chk($sformatf("drain occ%0d", k), 32'(occupancy), 32'(5 - k));
            nxt();
        end
        drv(1, 0, 0, 0, 1, 0);
        chk("drained occ", 32'(occupancy), 32'd0);
        chk("drained iv", 32'(i_valid), 32'd0);
        nxt();

        // reset mid-operation with three entries queued
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 0, 32'h500 + 32'(4 * k), 0, 0);
            nxt();
        end
        drv(1, 0, 0, 0, 0, 0);
        chk("pre-rst occ", 32'(occupancy), 32'd3);
        chk("pre-rst da", d_add, 32'h500);
        chk("pre-rst err", 32'(err_cnt), 32'd3);
        nxt();
        drv(0, 1, 0, 32'h5FF, 0, 1);
        chk("rst cyc occ", 32'(occupancy), 32'd0);
        chk("rst cyc dv", 32'(d_valid), 32'd0);
        chk("rst cyc da", d_add, 32'd0);
        chk("rst cyc rdy", 32'(cmd_ready), 32'd1);
        nxt();
        drv(1, 0, 0, 0, 0, 1);
        chk("post-rst occ", 32'(occupancy), 32'd0);
        chk("post-rst dv", 32'(d_valid), 32'd0);
        chk("post-rst err", 32'(err_cnt), 32'd0);
        chk("post-rst rdy", 32'(cmd_ready), 32'd1);
        nxt();
        drv(1, 1, 0, 32'h600, 0, 1);
        nxt();
        drv(1, 0, 0, 0, 0, 1);
        chk("new push dv", 32'(d_valid), 32'd1);
        chk("new push da", d_add, 32'h600);
        chk("new push op", 32'(d_op), 32'd0);
        nxt();
        drv(1, 0, 0, 0, 0, 1);
        chk("new push occ", 32'(occupancy), 32'd0);
        nxt();

        // err_cnt saturation: more illegal commands than the counter range
        clear = 1'b1; cmd_valid = 1'b1; cmd_n = 4'd5; cmd_add = '0;
        repeat (65540) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err sat", 32'(err_cnt), 32'h0000FFFF);
        chk("err sat occ", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
